// File: rtl/scene_int_seq.sv
// Issue-and-collect sequencer around the scene intersection datapath.
// Issues rays as X/Y/Z axis passes, tags results in flight, and buffers them in order.
module scene_int_seq #(
    parameter int unsigned PL_LATENCY = 45,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned RAY_W      = 64,
    parameter int unsigned FLOAT_W    = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [RAY_W-1:0]   ray_in,
    input  logic               ray_shadow_in,
    input  logic               ray_valid_in,
    output logic               ray_ready_out,
    output logic [RAY_W-1:0]   sint_ray,
    output logic               sint_v0,
    output logic               sint_v1,
    output logic               sint_v2,
    output logic               sint_is_shadow,
    input  logic [FLOAT_W-1:0] sint_tmin,
    input  logic [FLOAT_W-1:0] sint_tmax,
    input  logic               sint_miss,
    output logic [RAY_W-1:0]   out_ray,
    output logic [FLOAT_W-1:0] out_tmin,
    output logic [FLOAT_W-1:0] out_tmax,
    output logic               out_miss,
    output logic               out_valid,
    input  logic               out_stall
);

    localparam int unsigned PW    = $clog2(FIFO_DEPTH);
    localparam int unsigned RES_W = 2 * FLOAT_W + 1;
    localparam logic [PW:0] CreditMax = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StX, StY, StZ} state_e;

    state_e              state_q, state_d;
    logic [PW:0]         credits_q, credits_d;
    logic [RAY_W-1:0]    sint_ray_q, sint_ray_d;
    logic                shadow_q, shadow_d;
    logic [PL_LATENCY-1:0] tag_vld_q, tag_vld_d;
    logic [PL_LATENCY-1:0] tag_shd_q, tag_shd_d;
    logic [PW:0]         ray_wptr_q, ray_wptr_d;
    logic [PW:0]         res_wptr_q, res_wptr_d;
    logic [PW:0]         rd_ptr_q, rd_ptr_d;
    logic [RAY_W-1:0]    ray_mem_q [FIFO_DEPTH];
    logic [RES_W-1:0]    res_mem_q [FIFO_DEPTH];

    logic can_issue, accept, pop, res_we, res_empty, res_full;

    assign can_issue = (state_q == StIdle) || (state_q == StZ);
    assign res_empty = (res_wptr_q == rd_ptr_q);
    assign res_full  = (res_wptr_q[PW] != rd_ptr_q[PW]) &&
                       (res_wptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign out_valid = !res_empty;
    assign pop       = out_valid && !out_stall;
    // A pop in the same cycle frees a credit, so a full credit count can still accept.
    assign ray_ready_out = rst && can_issue && ((credits_q < CreditMax) || pop);
    assign accept    = ray_valid_in && ray_ready_out;
    assign res_we    = tag_vld_q[PL_LATENCY-1];

    assign sint_ray       = sint_ray_q;
    assign sint_v0        = (state_q == StX);
    assign sint_v1        = (state_q == StY);
    assign sint_v2        = (state_q == StZ);
    assign sint_is_shadow = tag_shd_q[PL_LATENCY-1];

    assign out_ray = ray_mem_q[rd_ptr_q[PW-1:0]];
    assign {out_tmin, out_tmax, out_miss} = res_mem_q[rd_ptr_q[PW-1:0]];

    always_comb begin
        state_d    = state_q;
        credits_d  = credits_q;
        sint_ray_d = sint_ray_q;
        shadow_d   = shadow_q;
        ray_wptr_d = ray_wptr_q;
        res_wptr_d = res_wptr_q;
        rd_ptr_d   = rd_ptr_q;

        unique case (state_q)
            StIdle:  if (accept) state_d = StX;
            StX:     state_d = StY;
            StY:     state_d = StZ;
            StZ:     state_d = accept ? StX : StIdle;
            default: state_d = StIdle;
        endcase

        if (accept) begin
            sint_ray_d = ray_in;
            shadow_d   = ray_shadow_in;
            ray_wptr_d = ray_wptr_q + 1'b1;
        end

        unique case ({accept, pop})
            2'b10:   credits_d = credits_q + 1'b1;
            2'b01:   credits_d = credits_q - 1'b1;
            default: credits_d = credits_q;
        endcase

        if (res_we) res_wptr_d = res_wptr_q + 1'b1;
        if (pop)    rd_ptr_d   = rd_ptr_q + 1'b1;

        // Tag enters on the v0 cycle so its tap lines up with the datapath result.
        tag_vld_d = {tag_vld_q[PL_LATENCY-2:0], state_q == StX};
        tag_shd_d = {tag_shd_q[PL_LATENCY-2:0], (state_q == StX) && shadow_q};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            credits_q  <= '0;
            sint_ray_q <= '0;
            shadow_q   <= 1'b0;
            tag_vld_q  <= '0;
            tag_shd_q  <= '0;
            ray_wptr_q <= '0;
            res_wptr_q <= '0;
            rd_ptr_q   <= '0;
            ray_mem_q  <= '{default: '0};
            res_mem_q  <= '{default: '0};
        end else begin
            state_q    <= state_d;
            credits_q  <= credits_d;
            sint_ray_q <= sint_ray_d;
            shadow_q   <= shadow_d;
            tag_vld_q  <= tag_vld_d;
            tag_shd_q  <= tag_shd_d;
            ray_wptr_q <= ray_wptr_d;
            res_wptr_q <= res_wptr_d;
            rd_ptr_q   <= rd_ptr_d;
            if (accept) ray_mem_q[ray_wptr_q[PW-1:0]] <= ray_in;
            if (res_we) res_mem_q[res_wptr_q[PW-1:0]] <= {sint_tmin, sint_tmax, sint_miss};
        end
    end

endmodule

// File: tb/tb_scene_int_seq.sv
// Scoreboard bench for scene_int_seq: a cycle-level reference model plus a datapath stub
// that returns a fixed function of each issued ray after the pipeline latency.
module tb_scene_int_seq;

    localparam int L = 45;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [63:0] ray_in = '0;
    logic        ray_shadow_in = 1'b0;
    logic        ray_valid_in = 1'b0;
    logic        ray_ready_out;
    logic [63:0] sint_ray;
    logic        sint_v0, sint_v1, sint_v2, sint_is_shadow;
    logic [31:0] sint_tmin = '0;
    logic [31:0] sint_tmax = '0;
    logic        sint_miss = 1'b0;
    logic [63:0] out_ray;
    logic [31:0] out_tmin, out_tmax;
    logic        out_miss, out_valid;
    logic        out_stall = 1'b0;

    scene_int_seq #(
        .PL_LATENCY(L),
        .FIFO_DEPTH(D),
        .RAY_W     (64),
        .FLOAT_W   (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ray_in        (ray_in),
        .ray_shadow_in (ray_shadow_in),
        .ray_valid_in  (ray_valid_in),
        .ray_ready_out (ray_ready_out),
        .sint_ray      (sint_ray),
        .sint_v0       (sint_v0),
        .sint_v1       (sint_v1),
        .sint_v2       (sint_v2),
        .sint_is_shadow(sint_is_shadow),
        .sint_tmin     (sint_tmin),
        .sint_tmax     (sint_tmax),
        .sint_miss     (sint_miss),
        .out_ray       (out_ray),
        .out_tmin      (out_tmin),
        .out_tmax      (out_tmax),
        .out_miss      (out_miss),
        .out_valid     (out_valid),
        .out_stall     (out_stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] ray;
        longint      wr;
    } exp_t;

    typedef struct {
        longint      due;
        logic [63:0] ray;
        logic        shd;
        bit          live;
    } dp_t;

    exp_t        exp_q[$];
    dp_t         dp_q[$];
    longint      cyc = 0;
    longint      last_acc = -100;
    logic [63:0] last_ray = '0;
    int          n_acc = 0;
    int          n_pop = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    function automatic logic [31:0] f_tmin(input logic [63:0] r);
        return r[31:0] ^ 32'h3f80_0000;
    endfunction
    function automatic logic [31:0] f_tmax(input logic [63:0] r);
        return r[63:32] + 32'd7;
    endfunction
    function automatic logic f_miss(input logic [63:0] r);
        return ^r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, req, cyc);
    endtask

    // Cycle bookkeeping and reset flush of the model.
    always @(posedge clk) begin
        if (rst && dut.res_we && dut.res_full) begin
            n_checks++;
            $display("FAIL res_overflow: result FIFO written while full (cycle %0d)", cyc);
        end
        cyc++;
        if (!rst) begin
            exp_q.delete();
            last_acc = -100;
            last_ray = '0;
            foreach (dp_q[i]) dp_q[i].live = 1'b0;
        end
    end

    // Issue-side model: handshake, selects, held ray, datapath stub, tag alignment.
    always @(negedge clk) begin
        longint c;
        logic   exp_pop, exp_rdy, shd_exp;
        logic [2:0] sel;
        dp_t    e;
        #1;
        c = cyc;
        exp_pop = rst && !out_stall && (exp_q.size() > 0) && (exp_q[0].wr < c);
        exp_rdy = rst && (c - last_acc >= 3) && ((exp_q.size() < D) || exp_pop);
        chk("ready", 64'(ray_ready_out), 64'(exp_rdy));
        case (c - last_acc)
            1:       sel = 3'b001;
            2:       sel = 3'b010;
            3:       sel = 3'b100;
            default: sel = 3'b000;
        endcase
        chk("axis_sel", 64'({sint_v2, sint_v1, sint_v0}), 64'(sel));
        chk("sint_ray", sint_ray, last_ray);
        shd_exp = 1'b0;
        if (dp_q.size() > 0 && dp_q[0].due == c) begin
            e = dp_q.pop_front();
            sint_tmin = f_tmin(e.ray);
            sint_tmax = f_tmax(e.ray);
            sint_miss = f_miss(e.ray);
            shd_exp   = e.live && e.shd;
        end else begin
            sint_tmin = $urandom;
            sint_tmax = $urandom;
            sint_miss = 1'($urandom_range(0, 1));
        end
        chk("is_shadow", 64'(sint_is_shadow), 64'(shd_exp));
        if (ray_valid_in && exp_rdy) begin
            n_acc++;
            exp_q.push_back('{ray: ray_in, wr: c + 1 + L});
            dp_q.push_back('{due: c + 1 + L, ray: ray_in, shd: ray_shadow_in, live: 1'b1});
            last_acc = c;
            last_ray = ray_in;
        end
    end

    // Output monitor: pops the scoreboard whenever the DUT pops its FIFO head.
    always @(negedge clk) begin
        longint c;
        logic   ev;
        exp_t   e;
        #2;
        c  = cyc;
        ev = (exp_q.size() > 0) && (exp_q[0].wr < c);
        chk("out_valid", 64'(out_valid), 64'(ev));
        if (rst && out_valid && !out_stall) begin
            if (!ev) begin
                n_checks++;
                $display("FAIL unexpected_out: out_ray %h with nothing due (cycle %0d)", out_ray, c);
            end else begin
                e = exp_q.pop_front();
                n_pop++;
                chk("out_ray", out_ray, e.ray);
                chk("out_tmin", 64'(out_tmin), 64'(f_tmin(e.ray)));
                chk("out_tmax", 64'(out_tmax), 64'(f_tmax(e.ray)));
                chk("out_miss", 64'(out_miss), 64'(f_miss(e.ray)));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_n(input int n, input logic stall_v);
        int target;
        int budget;
        target = n_acc + n;
        budget = 40 * n + 10;
        while (n_acc < target && budget > 0) begin
            ray_valid_in  = 1'b1;
            ray_in        = {$urandom, $urandom};
            ray_shadow_in = ~n_acc[0];
            out_stall     = stall_v;
            @(negedge clk);
            budget--;
        end
        ray_valid_in = 1'b0;
        chk("send_count", 64'(n_acc), 64'(target));
    endtask

    initial begin
        int a;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #3;
        chk("rst_out_ray", out_ray, 64'd0);
        chk("rst_out_tmin", 64'(out_tmin), 64'd0);
        chk("rst_out_tmax", 64'(out_tmax), 64'd0);
        chk("rst_out_miss", 64'(out_miss), 64'd0);
        @(negedge clk);

        send_n(1, 1'b0);
        idle(60);

        send_n(20, 1'b0);
        idle(60);

        // Stalled output: credits cap the number of accepted rays.
        a = n_acc;
        out_stall = 1'b1;
        ray_valid_in = 1'b1;
        repeat (30) begin
            ray_in = {$urandom, $urandom};
            ray_shadow_in = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        ray_valid_in = 1'b0;
        chk("stall_accepts", 64'(n_acc - a), 64'd4);
        idle(40);
        out_stall = 1'b0;
        @(negedge clk);
        out_stall = 1'b1;
        idle(2);

        // Refill to 4 credits, then pop and accept together in the Z cycle.
        send_n(1, 1'b1);
        @(negedge clk);
        @(negedge clk);
        a = n_acc;
        ray_valid_in = 1'b1;
        ray_in = {$urandom, $urandom};
        out_stall = 1'b0;
        @(negedge clk);
        ray_valid_in = 1'b0;
        out_stall = 1'b1;
        chk("bypass_accept", 64'(n_acc - a), 64'd1);
        out_stall = 1'b0;
        idle(60);

        // Reset with two rays in flight.
        send_n(2, 1'b0);
        idle(10);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        idle(60);
        send_n(1, 1'b0);
        idle(60);

        repeat (300) begin
            ray_valid_in  = 1'($urandom_range(0, 1));
            out_stall     = ($urandom_range(0, 3) == 0);
            ray_in        = {$urandom, $urandom};
            ray_shadow_in = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        ray_valid_in = 1'b0;
        out_stall = 1'b0;
        idle(80);
        chk("drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
